// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - command, status and data-memory bus bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // control unit command and status
   logic              start;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] memdatain;
   // data memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   // the controller itself
   modport slave (
      input  start, we, addr, wdata, mem_ack, mem_rdata,
      output busy, done, err, memdatain, mem_req, mem_we, mem_addr, mem_wdata
   );

   // control unit plus data memory, seen from outside the controller
   modport master (
      output start, we, addr, wdata, mem_ack, mem_rdata,
      input  busy, done, err, memdatain, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store req/ack controller feeding the MDR; optional MEM_TIMEOUT_EN abort
module mem_access_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_access_ctrl_if.slave   bus
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_access_ctrl: TIMEOUT must be 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   // state and datapath registers; async reset drops mem_req without a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // next state: accept a command in IDLE, wait for ack (or timeout) in ACCESS, one-cycle DONE
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               req_d   = 1'b1;
               state_d = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         S_ACCESS: begin
            // an ack on the same edge as the timeout limit takes priority
            if (bus.mem_ack) begin
               req_d   = 1'b0;
               state_d = S_DONE;
               if (!we_q) begin
                  rdata_d = bus.mem_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.memdatain = rdata_q;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule
